// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline package: default datapath width, branch-counter encodings,
// the BTB entry layout and the saturating-counter update helper.
package riscv_pipe_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // 2-bit saturating counter; bit 1 set means "predict taken".
    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } bht_ctr_e;

    // Tag and target are sized for the widest supported XLEN; narrower
    // configurations keep the upper bits at zero.
    typedef struct packed {
        logic                    valid;
        logic [XLEN_DEFAULT-1:0] tag;
        logic [XLEN_DEFAULT-1:0] target;
        bht_ctr_e                ctr;
    } btb_entry_t;

    function automatic bht_ctr_e ctr_update(bht_ctr_e ctr, logic taken);
        bht_ctr_e res;
        res = ctr;
        unique case (ctr)
            CtrSnt:  res = taken ? CtrWnt : CtrSnt;
            CtrWnt:  res = taken ? CtrWt  : CtrSnt;
            CtrWt:   res = taken ? CtrSt  : CtrWnt;
            CtrSt:   res = taken ? CtrSt  : CtrWt;
            default: res = ctr;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fetch_bpu_if.sv
// Fetch/branch-prediction bundle between the datapath and fetch_bpu.
//   F stage : StallF (in), PCF, PCPlus4F, PredTakenF, PredTargetF (out)
//   E stage : ValidE, BranchE, TakenE, PredTakenE, PCE, PCTargetE,
//             PredTargetE (in), MispredictE (out)
// master = datapath/hazard side, slave = fetch_bpu.
interface fetch_bpu_if #(
    parameter int unsigned XLEN = riscv_pipe_pkg::XLEN_DEFAULT
);
    logic            StallF;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCPlus4F;
    logic            PredTakenF;
    logic [XLEN-1:0] PredTargetF;

    logic            ValidE;
    logic            BranchE;
    logic            TakenE;
    logic            PredTakenE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCTargetE;
    logic [XLEN-1:0] PredTargetE;
    logic            MispredictE;

    modport master (
        output StallF, ValidE, BranchE, TakenE, PredTakenE, PCE, PCTargetE, PredTargetE,
        input  PCF, PCPlus4F, PredTakenF, PredTargetF, MispredictE
    );

    modport slave (
        input  StallF, ValidE, BranchE, TakenE, PredTakenE, PCE, PCTargetE, PredTargetE,
        output PCF, PCPlus4F, PredTakenF, PredTargetF, MispredictE
    );
endinterface

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
//   clk, rst          : clock, async active-high reset (clears all entries)
//   rd_pc_i           : fetch PC to look up
//   rd_hit_o          : indexed entry valid with matching tag
//   rd_taken_o        : hit and counter predicts taken
//   rd_target_o       : stored target of the indexed entry
//   upd_*_i           : E-stage resolution used to train the table
// Lookup reads the registered contents, so a same-cycle update to the same
// index is only visible on the following cycle.
module btb
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_hit_o,
    output logic            rd_taken_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            upd_valid_i,
    input  logic            upd_branch_i,
    input  logic            upd_taken_i,
    input  logic            upd_pred_taken_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_target_i
);
    localparam int unsigned IdxW = $clog2(ENTRIES);

    logic [IdxW-1:0]         rd_idx;
    logic [IdxW-1:0]         upd_idx;
    logic [XLEN_DEFAULT-1:0] rd_tag;
    logic [XLEN_DEFAULT-1:0] upd_tag;
    logic                    upd_hit;

    btb_entry_t mem_q [ENTRIES];
    btb_entry_t mem_d [ENTRIES];

    // Instructions are word aligned; the low two PC bits carry no information.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{rd_pc_i[1:0], upd_pc_i[1:0]};

    assign rd_idx  = rd_pc_i[IdxW+1:2];
    assign upd_idx = upd_pc_i[IdxW+1:2];
    assign rd_tag  = XLEN_DEFAULT'(rd_pc_i[XLEN-1:IdxW+2]);
    assign upd_tag = XLEN_DEFAULT'(upd_pc_i[XLEN-1:IdxW+2]);

    assign rd_hit_o    = mem_q[rd_idx].valid && (mem_q[rd_idx].tag == rd_tag);
    assign rd_taken_o  = rd_hit_o && mem_q[rd_idx].ctr[1];
    assign rd_target_o = mem_q[rd_idx].target[XLEN-1:0];

    assign upd_hit = mem_q[upd_idx].valid && (mem_q[upd_idx].tag == upd_tag);

    always_comb begin
        mem_d = mem_q;
        if (upd_valid_i) begin
            if (upd_branch_i) begin
                if (upd_hit) begin
                    mem_d[upd_idx].ctr = ctr_update(mem_q[upd_idx].ctr, upd_taken_i);
                    if (upd_taken_i) begin
                        mem_d[upd_idx].target = XLEN_DEFAULT'(upd_target_i);
                    end
                end else if (upd_taken_i) begin
                    mem_d[upd_idx] = '{valid:  1'b1,
                                       tag:    upd_tag,
                                       target: XLEN_DEFAULT'(upd_target_i),
                                       ctr:    CtrWt};
                end
            end else if (upd_pred_taken_i) begin
                // A non-branch was predicted taken: its index aliases a branch.
                mem_d[upd_idx].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CtrWnt};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_bpu.sv
// Fetch PC generation with BTB-based branch prediction.
//   clk, rst : clock, async active-high reset (PCF <- RESET_PC, BTB cleared)
//   bus      : fetch_bpu_if slave; F-stage PC/prediction outputs, E-stage
//              resolution inputs and the MispredictE redirect output.
// Next-PC priority: E-stage redirect, then stall hold, then predicted
// target, then sequential PC+4.
module fetch_bpu
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned     XLEN        = XLEN_DEFAULT,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_bpu_if.slave  bus
);
    logic [XLEN-1:0] pcf_q;
    logic [XLEN-1:0] pcf_d;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pce_plus4;
    logic [XLEN-1:0] btb_target;
    logic            btb_hit;
    logic            btb_taken;
    logic            mispredict;

    assign pc_plus4_f = pcf_q + XLEN'(4);
    assign pce_plus4  = bus.PCE + XLEN'(4);

    btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk              (clk),
        .rst              (rst),
        .rd_pc_i          (pcf_q),
        .rd_hit_o         (btb_hit),
        .rd_taken_o       (btb_taken),
        .rd_target_o      (btb_target),
        .upd_valid_i      (bus.ValidE),
        .upd_branch_i     (bus.BranchE),
        .upd_taken_i      (bus.TakenE),
        .upd_pred_taken_i (bus.PredTakenE),
        .upd_pc_i         (bus.PCE),
        .upd_target_i     (bus.PCTargetE)
    );

    always_comb begin
        mispredict = 1'b0;
        if (bus.ValidE) begin
            if (bus.BranchE) begin
                mispredict = (bus.TakenE != bus.PredTakenE) ||
                             (bus.TakenE && (bus.PCTargetE != bus.PredTargetE));
            end else begin
                mispredict = bus.PredTakenE;
            end
        end
    end

    always_comb begin
        pcf_d = pc_plus4_f;
        if (mispredict) begin
            pcf_d = (bus.TakenE && bus.BranchE) ? bus.PCTargetE : pce_plus4;
        end else if (bus.StallF) begin
            pcf_d = pcf_q;
        end else if (btb_taken) begin
            pcf_d = btb_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf_q <= RESET_PC;
        end else begin
            pcf_q <= pcf_d;
        end
    end

    assign bus.PCF         = pcf_q;
    assign bus.PCPlus4F    = pc_plus4_f;
    assign bus.PredTakenF  = btb_taken;
    assign bus.PredTargetF = btb_hit ? btb_target : pc_plus4_f;
    assign bus.MispredictE = mispredict;

endmodule
